sseg_scan_driver: RTL
=====================

// Module: sseg_scan_driver
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment driver; next generation of the board display path.
//  Owns the refresh prescaler, digit scan, hex decode, decimal points, per-digit enable,
//  leading-zero blanking, PWM brightness and tear-free frame-synchronous value update.
//  Sits between user logic (value/dp/load) and the board anode/cathode pins.
// PARAMETERS
//  NUM_DIGITS  8       digits scanned (1..16)
//  TICK_DIV    100000  clk cycles per digit slot (>= GUARD+2)
//  GUARD       16      cycles at start of each slot with all anodes off (anti-ghosting)
//  BRIGHT_W    4       brightness/PWM counter width
// PORTS
//  clk         in   1              system clock, all logic rising-edge
//  reset       in   1              synchronous, active-high
//  value       in   4*NUM_DIGITS   hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//  dp          in   NUM_DIGITS     decimal point per digit, 1 = lit
//  digit_en    in   NUM_DIGITS     1 = digit may light; 0 = dark, slot still consumed
//  blank_lz    in   1              1 = blank leading zeros
//  brightness  in   BRIGHT_W       0 = dimmest (1/2^BRIGHT_W duty), all-ones = full
//  load        in   1              1-cycle strobe: capture value/dp/digit_en
//  anode       out  NUM_DIGITS     active-low digit selects, registered
//  cathode     out  8              active-low {dp,g,f,e,d,c,b,a}, registered
//  frame_done  out  1              1-cycle pulse when scan wraps N-1 -> 0
// BEHAVIOUR
//  Reset: anode all 1, cathode 8'hFF, frame_done 0, presc 0, idx 0, pwm 0,
//   display regs (val/dp/en) 0, pending_valid 0. Reset mid-frame discards pending load.
//  presc: 0..TICK_DIV-1, wraps; tick = (presc==TICK_DIV-1).
//  idx: advances on tick, wraps NUM_DIGITS-1 -> 0; on that wrap, boundary=1.
//  frame_done: registered; high the cycle after the boundary tick, for exactly 1 cycle.
//  Load/shadow: load copies inputs to pending, sets pending_valid (later load overwrites).
//   On boundary, if pending_valid: display <= pending, pending_valid <= 0.
//   load coincident with boundary: inputs go straight to display, pending_valid <= 0.
//   Display never changes mid-frame.
//  pwm: BRIGHT_W-bit free-running counter, +1 every clk, wraps.
//  lit(i) = en[i] & ~lz_blank(i) & (presc >= GUARD) & (pwm <= brightness).
//  lz_blank(i): blank_lz=1 and every digit j>=i has nibble 0 and dp 0; digit 0 never blanked.
//   Digits with en=0 do not break the zero run (treated as zero).
//  anode <= ~(one-hot(idx)) when lit(idx), else all 1. One register stage: output
//   reflects idx/presc/pwm of the previous cycle (latency 1 clk).
//  cathode <= {~dp[idx], seg7(nibble[idx])} when lit(idx), else 8'hFF.
//  seg7 (active-low g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//   C=1000110 d=0100001 E=0000110 F=0001110.
//  brightness and blank_lz act immediately (not shadowed).
//  Never more than one anode low; anode/cathode glitch-free (registered).
// TESTING (bench params NUM_DIGITS=4, TICK_DIV=8, GUARD=1, BRIGHT_W=2)
//  reset 3 cycles -> anode=4'hF, cathode=8'hFF, frame_done=0; release, brightness=3,
//   en=4'hF, load value=16'h12AF -> after next frame_done, slot 0 shows
//   anode=4'b1110 cathode=8'b10001110 (F), slot 3 anode=4'b0111 cathode=8'b11111001 (1).
//  frame_done period = 32 cycles, width 1; first presc cycle of each slot -> anode=4'hF.
//  value=16'h0070, dp=0, blank_lz=1 -> digits 3,2 dark, digit 1 '7', digit 0 '0';
//   dp[2]=1 -> digit 2 shows '0.' and digit 3 still dark.
//  load 16'h1111 mid-frame -> display unchanged until boundary; load coincident
//   with boundary tick -> new value in the first slot of the next frame.
//  brightness=0 -> anode low exactly 1 cycle in 4 within lit slot region;
//   brightness=2 -> 3 in 4; en=4'b1011 -> digit 2 never low, slot timing unchanged.
//  assert reset mid-slot with pending load -> outputs 4'hF/8'hFF next cycle; after release
//   display value is 0 (pending discarded).

Source files
------------

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//   Multiplexed N-digit seven-segment display driver. It contains the refresh
//   prescaler, the digit scan, hex-to-segment decode, decimal points, per-digit
//   enables, leading-zero blanking and PWM brightness. New values are taken
//   only at frame boundaries, so a frame never shows a mix of old and new data.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   value       hex nibbles; digit i = value[4i+3:4i], digit 0 is rightmost
//   dp          decimal point per digit, 1 = lit
//   digit_en    1 = digit may light; 0 = dark, but its slot is still scanned
//   blank_lz    1 = blank leading zeros (applies immediately)
//   brightness  PWM threshold; 0 = dimmest, all-ones = full (applies immediately)
//   load        1-cycle strobe that captures value/dp/digit_en
//   anode       active-low digit selects, registered
//   cathode     active-low {dp,g,f,e,d,c,b,a}, registered
//   frame_done  1-cycle pulse the cycle after the scan wraps N-1 -> 0
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000,
  parameter int GUARD      = 16,
  parameter int BRIGHT_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      blank_lz,
  input  logic [BRIGHT_W-1:0]       brightness,
  input  logic                      load,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [7:0]                cathode,
  output logic                      frame_done
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] GUARD_END  = PRESC_W'(GUARD);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    seg7 = 7'b1111111;
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      4'hF: seg7 = 7'b0001110;
    endcase
  endfunction

  // Scan timing
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic                    frame_done_q, frame_done_d;

  // Displayed (frame-stable) data and the pending shadow copy
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_en_q, disp_en_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_valid_q, pend_valid_d;

  // Output registers
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;

  logic                    tick;
  logic                    boundary;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    lit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    presc_d      = presc_q + 1'b1;
    idx_d        = idx_q;
    pwm_d        = pwm_q + 1'b1;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_en_d    = disp_en_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    anode_d      = '1;
    cathode_d    = 8'hFF;

    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    frame_done_d = boundary;

    if (tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Display data only moves at the frame boundary. A load landing exactly
    // on the boundary bypasses the shadow and supersedes anything pending.
    if (boundary) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp;
        disp_en_d  = digit_en;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
        disp_en_d  = pend_en_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_en_d    = digit_en;
      pend_valid_d = 1'b1;
    end

    // Walk from the most significant digit down; the run of zeros survives
    // while each digit is zero with no dp, or is disabled. Digit 0 always shows.
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (~disp_en_q[i] |
                    ((disp_val_q[4*i +: 4] == 4'h0) & ~disp_dp_q[i]));
      lz_blank[i] = blank_lz & zero_run & (i != 0);
    end

    cur_nib = disp_val_q[4*idx_q +: 4];
    lit     = disp_en_q[idx_q] & ~lz_blank[idx_q] &
              (presc_q >= GUARD_END) & (pwm_q <= brightness);

    if (lit) begin
      anode_d[idx_q] = 1'b0;
      cathode_d      = {~disp_dp_q[idx_q], seg7(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      frame_done_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_en_q    <= '0;
      pend_valid_q <= 1'b0;
      anode_q      <= '1;
      cathode_q    <= 8'hFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      frame_done_q <= frame_done_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_en_q    <= disp_en_d;
      pend_valid_q <= pend_valid_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
    end
  end

  // NOTE: the pending data payload has no reset; it is only ever consumed
  // when pend_valid_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    pend_val_q <= pend_val_d;
    pend_dp_q  <= pend_dp_d;
    pend_en_q  <= pend_en_d;
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule
